simd_lane_collector: RTL



---
 rtl/simd_lane_collector_if.sv | 26 ++
 rtl/simd_lane_collector.sv | 122 ++++++++++++
 2 files changed

// File: rtl/simd_lane_collector_if.sv
// Handshake bundle between the SIMD result producer and the lane collector.
// slave = collector side, master = producer/consumer side.
interface simd_lane_collector_if #(
   parameter int NUM_LANES = 10,
   parameter int LANE_W    = 16,
   parameter int IDX_W     = 4
);
   logic                          in_valid;
   logic                          in_ready;
   logic [NUM_LANES*LANE_W-1:0]   lanes_in;
   logic                          out_valid;
   logic                          out_ready;
   logic [LANE_W-1:0]             out_data;
   logic [IDX_W-1:0]              out_index;
   logic                          out_last;

   modport master (
      output in_valid, lanes_in, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_last
   );

   modport slave (
      input  in_valid, lanes_in, out_ready,
      output in_ready, out_valid, out_data, out_index, out_last
   );
endinterface

// File: rtl/simd_lane_collector.sv
// Captures NUM_LANES SIMD results in one cycle and streams them one lane per beat.
// Define SIMD_REDUCE_EN to append a reduction-sum beat (index NUM_LANES) to each packet.
module simd_lane_reg #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (ld) q <= d;
   end
endmodule

module simd_lane_collector #(
   parameter int NUM_LANES = 10,
   parameter int LANE_W    = 16,
   parameter int IDX_W     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   simd_lane_collector_if.slave   bus,
   output logic [7:0]             pkt_count
);
`ifdef SIMD_REDUCE_EN
   localparam int NUM_BEATS = NUM_LANES + 1;
   localparam logic [IDX_W-1:0] SUM_IDX = IDX_W'(NUM_LANES);
`else
   localparam int NUM_BEATS = NUM_LANES;
`endif
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                          state_q, state_d;
   logic [NUM_LANES-1:0][LANE_W-1:0] buf_q;
   logic [IDX_W-1:0]                idx_q;
   logic                            cap, beat, last_beat;

   // Both handshakes are decoded from the registered state so the FSM has no comb loop.
   assign cap       = bus.in_valid && (state_q == IDLE);
   assign beat      = (state_q == SEND) && bus.out_ready;
   assign last_beat = beat && (idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (cap) state_d = SEND;
         end
         SEND: begin
            bus.out_valid = 1'b1;
            if (last_beat) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      simd_lane_reg #(.W(LANE_W)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .ld    (cap),
         .d     (bus.lanes_in[k*LANE_W +: LANE_W]),
         .q     (buf_q[k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         pkt_count <= '0;
      end else begin
         if (cap)                     idx_q <= '0;
         else if (beat && !last_beat) idx_q <= idx_q + 1'b1;
         if (last_beat)               pkt_count <= pkt_count + 8'd1;
      end
   end

`ifdef SIMD_REDUCE_EN
   logic [LANE_W-1:0] sum_in, sum_q;

   // Summed from lanes_in at capture, so stalls can never desynchronise it from buf_q.
   always_comb begin
      sum_in = '0;
      for (int k = 0; k < NUM_LANES; k++)
         sum_in = sum_in + bus.lanes_in[k*LANE_W +: LANE_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   sum_q <= '0;
      else if (cap) sum_q <= sum_in;
   end
`endif

   always_comb begin
      bus.out_data  = '0;
      bus.out_index = '0;
      bus.out_last  = 1'b0;
      if (state_q == SEND) begin
         bus.out_index = idx_q;
         bus.out_last  = (idx_q == LAST_IDX);
`ifdef SIMD_REDUCE_EN
         if (idx_q == SUM_IDX) bus.out_data = sum_q;
         else                  bus.out_data = buf_q[idx_q];
`else
         bus.out_data = buf_q[idx_q];
`endif
      end
   end
endmodule
